// File: rtl/imm_pkg.sv
// Shared encodings and helpers for the registered RISC-V immediate generator.
`default_nettype none

package imm_pkg;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_SHAMT = 3'b001;
    localparam logic [2:0] IMM_S     = 3'b010;
    localparam logic [2:0] IMM_B     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_J     = 3'b101;
    localparam logic [2:0] IMM_Z     = 3'b110;
    localparam logic [2:0] IMM_RSV   = 3'b111;

    // State code is {out_valid, skid_valid}, so the flags are read directly off the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } pipe_state_e;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bundle between decode and the immediate generator and its consumer.
`default_nettype none

interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [2:0]        in_sel;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic [TAG_W-1:0]  out_tag;
    logic              out_illegal;

    modport slave (
        input  in_valid, in_instr, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface

`default_nettype wire

// File: rtl/imm_extract.sv
// Combinational immediate extraction and XLEN extension for one instruction word.
`default_nettype none

module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [31:0]     instr_i,
    input  wire logic [2:0]      sel_i,
    output logic      [XLEN-1:0] imm_o,
    output logic                 illegal_o
);

    // The opcode field never contributes to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    always_comb begin
        imm_o     = '0;
        illegal_o = 1'b0;
        case (sel_i)
            IMM_I:     imm_o = XLEN'($signed(instr_i[31:20]));
            IMM_SHAMT: imm_o = (XLEN == 64) ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
            IMM_S:     imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            IMM_B:     imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                              instr_i[11:8], 1'b0}));
            IMM_U:     imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
            IMM_J:     imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                              instr_i[30:21], 1'b0}));
            IMM_Z:     imm_o = XLEN'(instr_i[19:15]);
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready flow control, one skid entry and flush.
`default_nettype none

module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          flush,
    imm_gen_pipe_if.slave      bus
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  ext_imm;
    logic             ext_illegal;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr_i   (bus.in_instr),
        .sel_i     (bus.in_sel),
        .imm_o     (ext_imm),
        .illegal_o (ext_illegal)
    );

    pipe_state_e      state_q;
    logic [XLEN-1:0]  out_imm_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_illegal_q;
    logic [XLEN-1:0]  skid_imm_q;
    logic [TAG_W-1:0] skid_tag_q;
    logic             skid_illegal_q;

    logic in_fire;
    logic out_fire;

    // in_ready comes straight from the skid flag, so out_ready never reaches it combinationally.
    assign bus.in_ready    = ~state_q[0];
    assign bus.out_valid   = state_q[1];
    assign bus.out_imm     = out_imm_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_illegal = out_illegal_q;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_EMPTY;
            out_imm_q      <= '0;
            out_tag_q      <= '0;
            out_illegal_q  <= 1'b0;
            skid_imm_q     <= '0;
            skid_tag_q     <= '0;
            skid_illegal_q <= 1'b0;
        end else if (flush) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        out_imm_q     <= ext_imm;
                        out_tag_q     <= bus.in_tag;
                        out_illegal_q <= ext_illegal;
                        state_q       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        out_imm_q     <= ext_imm;
                        out_tag_q     <= bus.in_tag;
                        out_illegal_q <= ext_illegal;
                    end else if (in_fire) begin
                        skid_imm_q     <= ext_imm;
                        skid_tag_q     <= bus.in_tag;
                        skid_illegal_q <= ext_illegal;
                        state_q        <= ST_FULL;
                    end else if (out_fire) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        out_imm_q     <= skid_imm_q;
                        out_tag_q     <= skid_tag_q;
                        out_illegal_q <= skid_illegal_q;
                        state_q       <= ST_ONE;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, flow-controlled immediate generator for the decode stage of the RISC-V core. Extracts and sign- or zero-extends the immediate of an incoming 32-bit instruction word to XLEN bits, covering RV32 and RV64. Carries a sideband tag (PC or ROB index) alongside the result. Sits between fetch/decode and the ID/EX register, with valid/ready handshakes, a skid buffer and flush.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, sideband tag width; must be ≥1.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  instruction presented.
- in_ready  out  1  block can accept an instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_sel  in  3  immediate type select.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag matching out_imm.
- out_illegal  out  1  in_sel was reserved (111).

## Operation
- in_sel encodings:
  - 000 I: instr[31:20], sign-extended.
  - 001 SHAMT: instr[24:20] zero-extended when XLEN=32; instr[25:20] zero-extended when XLEN=64.
  - 010 S: {instr[31:25],instr[11:7]}, sign-extended.
  - 011 B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}, sign-extended.
  - 100 U: {instr[31:12],12'b0}, sign-extended to XLEN.
  - 101 J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}, sign-extended.
  - 110 Z (CSR zimm): instr[19:15] zero-extended.
  - 111: out_imm=0, out_illegal=1.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Storage: output register plus one skid entry.
  - Output register loads when it is empty or draining this cycle. Source is the skid entry if occupied, otherwise the input.
  - An input accepted while the output register holds and out_ready=0 goes to the skid entry.
- in_ready = !skid_valid. Taken from a register, with no combinational path from out_ready.
- States, derived from {out_valid, skid_valid}:
  - EMPTY {0,0}.
  - ONE {1,0}.
  - FULL {1,1}.
  - {0,1} is unreachable.
- Transitions:
  - EMPTY→ONE on input.
  - ONE→EMPTY on output without input.
  - ONE→FULL on input without output.
  - FULL→ONE on output; the skid entry moves to the output register. No input is possible in FULL.
  - ONE with simultaneous input and output stays ONE, and the output register takes the new input.
- Flush:
  - Next edge clears out_valid and skid_valid.
  - An input handshake in the flush cycle is discarded.
  - flush has priority over all other events.
- The tag always travels with its immediate, and ordering is preserved.

## Timing
- Latency: 1 cycle from input handshake to out_valid, when empty.
- Throughput: 1 per cycle while out_ready=1.
- Reset (asynchronous) values:
  - out_valid=0, out_imm=0, out_tag=0, out_illegal=0.
  - skid cleared, so in_ready=1.
- Reset mid-operation drops all held entries immediately, with no completion.
- While out_valid=1 && out_ready=0, out_imm, out_tag and out_illegal hold stable.
- Data registers load only on a transfer. Values in EMPTY are don't-care, except after reset.

## Structure
- Package imm_pkg:
  - Localparams IMM_I, IMM_SHAMT, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_RSV (3 bits each).
  - Parameter-checking elaboration assertion: XLEN ∈ {32,64}.
- Sub-module imm_extract: purely combinational (instr, sel) → (imm[XLEN-1:0], illegal), parametrised by XLEN.
- imm_gen_pipe instantiates imm_extract once on the input side, and registers only the extracted results.

## Test plan
- XLEN=32, in_sel=000, instr=0xFFB00000 → out_imm=0xFFFFFFFB one cycle later. Then SHAMT with 0x00400000 → 0x00000004.
- XLEN=32 back-to-back, out_ready=1:
  - S 0xFE000E00 → 0xFFFFFFFC.
  - B 0x28000300 → 0x00000286.
  - U 0x12345000 → 0x12345000.
  - J 0xAAAAA000 → 0xFFFAA2AA.
  - Each output appears one cycle after its input, at one per cycle.
- XLEN=64:
  - U 0x12345000 → 0x0000000012345000.
  - I 0xFFB00000 → 0xFFFFFFFFFFFFFFFB.
  - SHAMT 0x03F00000 → 0x3F.
  - Z 0x000F8000 → 0x1F.
- Backpressure:
  - Hold out_ready=0 and send tags 1, 2, 3 → in_ready drops after tag 2 is accepted; tag 3 waits.
  - Release out_ready → tags 1, 2, 3 emerge in order with their matching immediates.
- in_sel=111 → out_illegal=1, out_imm=0. The following valid I-type clears out_illegal.
- Flush and reset:
  - In FULL, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, and nothing emerges.
  - Assert rst asynchronously mid-stream → outputs go to reset values without waiting for a clock edge.
